// File: rtl/fixed_power.sv
// Iterative unsigned fixed-point power unit: out = base^n, one truncating
// multiply per cycle, saturating to all-ones once any partial product overflows.
module fixed_power #(
    parameter int INT_W  = 10,
    parameter int FRAC_W = 10,
    parameter int EXP_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [INT_W+FRAC_W-1:0] in_data_1,
    input  logic [EXP_W-1:0]        in_data_2,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [INT_W+FRAC_W-1:0] out_data,
    output logic                    out_overflow
);

    localparam int W = INT_W + FRAC_W;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << FRAC_W;
    localparam logic [W-1:0] SAT = {W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     base_q, base_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_ovf_q, out_ovf_d;

    // Full-width product realigned to Q format; any set bit above the
    // integer field means the partial result no longer fits.
    logic [2*W-1:0] prod_shifted;
    logic           prod_ovf;

    assign prod_shifted = ({{W{1'b0}}, acc_q} * {{W{1'b0}}, base_q}) >> FRAC_W;
    assign prod_ovf     = |prod_shifted[2*W-1:W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    base_d  = in_data_1;
                    cnt_d   = in_data_2;
                    acc_d   = ONE;
                    ovf_d   = 1'b0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    out_data_d  = acc_q;
                    out_ovf_d   = ovf_q;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    // Once saturated, stay saturated for the rest of the request.
                    if (ovf_q || prod_ovf) begin
                        acc_d = SAT;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = prod_shifted[W-1:0];
                    end
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_fixed_power.sv
// Scoreboard bench for fixed_power: expected results are queued at drive time
// and matched, with their due cycle, when out_valid pulses.
module tb_fixed_power;

    typedef struct {
        logic [19:0] data;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [19:0] in_data_1;
    logic [2:0]  in_data_2;
    logic        in_ready;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_overflow;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];
    int   due_q[$];

    fixed_power #(.INT_W(10), .FRAC_W(10), .EXP_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data_1    (in_data_1),
        .in_data_2    (in_data_2),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: repeated multiply in wide arithmetic, truncate, sticky saturate.
    function automatic exp_t model(input logic [19:0] b, input int n);
        exp_t        r;
        logic [63:0] acc;
        logic [63:0] p;
        acc   = 64'd1024;
        r.ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (r.ovf) begin
                acc = 64'hFFFFF;
            end else begin
                p = (acc * {44'd0, b}) >> 10;
                if (p > 64'hFFFFF) begin
                    acc   = 64'hFFFFF;
                    r.ovf = 1'b1;
                end else begin
                    acc = p;
                end
            end
        end
        r.data = acc[19:0];
        return r;
    endfunction

    // Acceptance monitor records the cycle on which out_valid must appear.
    always @(posedge clk) begin
        if (!rst_n)
            due_q.delete();
        else if (in_valid && in_ready)
            due_q.push_back(cyc + int'(in_data_2) + 2);
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", {12'd0, out_data}, {12'd0, e.data});
                chk("out_overflow", {31'd0, out_overflow}, {31'd0, e.ovf});
            end
            if (due_q.size() == 0)
                chk("latency_missing", 32'd1, 32'd0);
            else
                chk("latency", cyc, due_q.pop_front());
        end
    end

    task automatic send(input logic [19:0] b, input logic [2:0] n,
                        input logic [19:0] ed, input logic eo);
        exp_t e;
        int   t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
        in_valid  = 1'b1;
        in_data_1 = b;
        in_data_2 = n;
        e.data    = ed;
        e.ovf     = eo;
        sb.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic send_model(input logic [19:0] b, input logic [2:0] n);
        exp_t e;
        e = model(b, int'(n));
        send(b, n, e.data, e.ovf);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data_1 = '0;
        in_data_2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {12'd0, out_data}, 32'd0);
        chk("rst_out_overflow", {31'd0, out_overflow}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values with hand-derived results
        send(20'h00800, 3'd3, 20'h02000, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        chk("hold_out_data", {12'd0, out_data}, 32'h02000);
        send(20'h00600, 3'd2, 20'h00900, 1'b0);
        drain();
        send(20'h00000, 3'd0, 20'h00400, 1'b0);
        drain();
        send(20'h12345, 3'd0, 20'h00400, 1'b0);
        drain();
        send(20'h00000, 3'd5, 20'h00000, 1'b0);
        drain();
        send(20'h12345, 3'd1, 20'h12345, 1'b0);
        drain();
        send(20'h00401, 3'd7, 20'h00407, 1'b0);
        drain();
        send(20'h04000, 3'd3, 20'hFFFFF, 1'b1);
        drain();
        send(20'hFFFFF, 3'd7, 20'hFFFFF, 1'b1);
        drain();
        send(20'h04000, 3'd2, 20'h40000, 1'b0);
        drain();

        // in_valid while busy must be ignored
        send(20'h00800, 3'd7, 20'h20000, 1'b0);
        in_valid  = 1'b1;
        in_data_1 = 20'h00C00;
        in_data_2 = 3'd1;
        repeat (3) @(negedge clk);
        in_valid  = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        // Reset in the middle of a MUL sequence aborts the request
        send(20'h00800, 3'd7, 20'h20000, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out_data", {12'd0, out_data}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (15) @(negedge clk);

        // Back-to-back at in_ready
        send_model(20'h00600, 3'd2);
        send_model(20'h00A00, 3'd4);
        send_model(20'h00200, 3'd3);
        send_model(20'h08000, 3'd2);
        drain();

        // Random operands through the reference model
        for (int i = 0; i < 12; i++) begin
            logic [19:0] b;
            logic [2:0]  n;
            b = (i % 2 == 0) ? 20'($urandom_range(0, 32'h01800)) : 20'($urandom);
            n = 3'($urandom_range(0, 7));
            send_model(b, n);
        end
        drain();
        chk("latency_queue_empty", due_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
